main_mem_ctrl: RTL and testbench

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

---
 rtl/main_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_main_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: cache-side memory controller, fixed-latency reads, posted writes via a small FIFO buffer.
// Latency: data_valid rises RD_LAT cycles after a new-read edge; a write posts in 1 cycle; the buffer drains 1 entry/cycle.
// Backpressure: none toward the cache; a write that meets a full, non-draining buffer is dropped and wb_overflow is set.
module main_mem_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter int RD_LAT    = 3,
  parameter int WB_DEPTH  = 4
) (
  input  logic        clk_100,
  input  logic        rst_n,
  input  logic [15:0] addr_in,
  input  logic [15:0] data_in,
  input  logic        write_en,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        wb_full,
  output logic        wb_overflow
);

  localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W = $clog2(WB_DEPTH + 1);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD, WR} state_t;

  state_t               state;
  logic [2:0]           lat_cnt;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 last_we;

  // backing RAM and write-buffer storage carry no reset
  logic [15:0]          mem     [DEPTH];
  logic [ADDR_BITS-1:0] wb_addr [WB_DEPTH];
  logic [15:0]          wb_data [WB_DEPTH];

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nxt;

  logic                 last_wr_vld;
  logic [ADDR_BITS-1:0] last_wr_addr;
  logic [15:0]          last_wr_data;

  logic [ADDR_BITS-1:0] addr_lo;
  logic                 new_read;
  logic                 dup_wr;
  logic                 push_req;
  logic                 push_ok;
  logic                 drain;
  logic [15:0]          rd_word;

  // Upper address bits alias onto the same word and are intentionally dropped.
  logic                 unused_addr_hi;
  assign unused_addr_hi = ^addr_in[15:ADDR_BITS];
  assign addr_lo        = addr_in[ADDR_BITS-1:0];

  // Hold-off point for the drain path; tied low so the buffer always drains when non-empty.
  logic                 drain_stall;
  assign drain_stall = 1'b0;

  // Request classification: new-read detect, duplicate-write filter, push/drain enables, next count
  always_comb begin
    new_read  = !write_en && ((addr_lo != rd_addr) || last_we || (state == IDLE));
    dup_wr    = last_we && last_wr_vld && (addr_lo == last_wr_addr) && (data_in == last_wr_data);
    push_req  = write_en && !dup_wr;
    drain     = (count != '0) && !drain_stall;
    push_ok   = push_req && ((count != CNT_W'(WB_DEPTH)) || drain);
    count_nxt = count + CNT_W'(push_ok) - CNT_W'(drain);
  end

  // Read lookup for the held address: newest matching buffer entry wins, else the RAM word
  always_comb begin
    rd_word = mem[rd_addr];
    for (int k = 0; k < WB_DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (wb_addr[rd_ptr + PTR_W'(k)] == rd_addr)) begin
        rd_word = wb_data[rd_ptr + PTR_W'(k)];
      end
    end
  end

  // Control FSM: write requests win, then new reads restart latency, else count down / hold
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      rd_addr    <= '0;
      last_we    <= 1'b0;
      data_out   <= 16'h0000;
      data_valid <= 1'b0;
    end else begin
      last_we <= write_en;
      if (write_en) begin
        state      <= WR;
        data_valid <= 1'b0;
      end else if (new_read) begin
        state      <= RD_WAIT;
        rd_addr    <= addr_lo;
        lat_cnt    <= 3'(RD_LAT - 1);
        data_valid <= 1'b0;
      end else begin
        case (state)
          RD_WAIT: begin
            if (lat_cnt == 3'd0) begin
              data_out   <= rd_word;
              data_valid <= 1'b1;
              state      <= RD_HOLD;
            end else begin
              lat_cnt <= lat_cnt - 3'd1;
            end
          end
          // keep tracking drains/forwards to the held address
          RD_HOLD: data_out <= rd_word;
          // IDLE and WR with write_en=0 always classify as a new read above
          default: ;
        endcase
      end
    end
  end

  // Write-buffer bookkeeping: pointers, count, status flags and last accepted pair
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      busy         <= 1'b0;
      wb_full      <= 1'b0;
      wb_overflow  <= 1'b0;
      last_wr_vld  <= 1'b0;
      last_wr_addr <= '0;
      last_wr_data <= 16'h0000;
    end else begin
      if (push_ok) begin
        wr_ptr       <= wr_ptr + PTR_W'(1);
        last_wr_vld  <= 1'b1;
        last_wr_addr <= addr_lo;
        last_wr_data <= data_in;
      end
      if (drain) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_req && !push_ok) begin
        wb_overflow <= 1'b1;
      end
      count   <= count_nxt;
      busy    <= (count_nxt != '0);
      wb_full <= (count_nxt == CNT_W'(WB_DEPTH));
    end
  end

  // Buffer entry capture and drain of the oldest entry into RAM (count is 0 while in reset)
  always_ff @(posedge clk_100) begin
    if (push_ok) begin
      wb_addr[wr_ptr] <= addr_lo;
      wb_data[wr_ptr] <= data_in;
    end
    if (drain) begin
      mem[wb_addr[rd_ptr]] <= wb_data[rd_ptr];
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl: directed + randomized checks of main_mem_ctrl against a queue/array reference model.
// Latency: reads are checked cycle-exactly (data_valid low for RD_LAT edges, high on the next).
// Backpressure: buffer fill is provoked by forcing the internal drain hold-off.
module tb_main_mem_ctrl;

  localparam int ADDR_BITS = 8;
  localparam int RD_LAT    = 3;
  localparam int WB_DEPTH  = 4;

  logic        clk_100;
  logic        rst_n;
  logic [15:0] addr_in;
  logic [15:0] data_in;
  logic        write_en;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        wb_full;
  logic        wb_overflow;

  int total = 0;
  int bad   = 0;

  main_mem_ctrl #(
    .ADDR_BITS (ADDR_BITS),
    .RD_LAT    (RD_LAT),
    .WB_DEPTH  (WB_DEPTH)
  ) dut (
    .clk_100     (clk_100),
    .rst_n       (rst_n),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .write_en    (write_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .wb_full     (wb_full),
    .wb_overflow (wb_overflow)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  // ---------------- reference model ----------------
  logic [15:0] shadow [256];
  logic [7:0]  q_addr [$];
  logic [15:0] q_data [$];
  bit          stalled    = 0;
  bit          m_ovf      = 0;
  bit          m_prev_we  = 0;
  bit          m_last_vld = 0;
  logic [7:0]  m_last_a   = 8'h00;
  logic [15:0] m_last_d   = 16'h0000;
  bit          hold_valid = 0;
  logic [7:0]  hold_lo    = 8'h00;

  function automatic void m_write(input logic [7:0] a, input logic [15:0] d);
    if (m_prev_we && m_last_vld && a == m_last_a && d == m_last_d) return;
    if (!stalled) begin
      shadow[a]  = d;
    end else if (q_addr.size() < WB_DEPTH) begin
      q_addr.push_back(a);
      q_data.push_back(d);
    end else begin
      m_ovf = 1;
      return;
    end
    m_last_vld = 1;
    m_last_a   = a;
    m_last_d   = d;
  endfunction

  function automatic logic [15:0] m_read(input logic [7:0] a);
    logic [15:0] v;
    v = shadow[a];
    for (int i = 0; i < q_addr.size(); i++)
      if (q_addr[i] == a) v = q_data[i];
    return v;
  endfunction

  function automatic void m_release();
    for (int i = 0; i < q_addr.size(); i++) shadow[q_addr[i]] = q_data[i];
    q_addr.delete();
    q_data.delete();
  endfunction

  function automatic void m_reset();
    q_addr.delete();
    q_data.delete();
    m_ovf      = 0;
    m_prev_we  = 0;
    m_last_vld = 0;
    hold_valid = 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    addr_in  = a;
    data_in  = d;
    write_en = 1'b1;
    m_write(a[7:0], d);
    m_prev_we  = 1;
    hold_valid = 0;
    tick();
  endtask

  task automatic idle(input int n);
    write_en   = 1'b0;
    m_prev_we  = 0;
    hold_valid = 1;
    hold_lo    = addr_in[7:0];
    repeat (n) tick();
  endtask

  // New read of a: data_valid low at the new-read edge and RD_LAT-1 more, high on edge RD_LAT
  task automatic do_read(input string tag, input logic [15:0] a);
    logic [15:0] exp;
    addr_in    = a;
    write_en   = 1'b0;
    m_prev_we  = 0;
    hold_valid = 1;
    hold_lo    = a[7:0];
    exp        = m_read(a[7:0]);
    tick();
    chk({tag, "_dv_e0"}, {15'd0, data_valid}, 16'd0);
    for (int i = 1; i < RD_LAT; i++) begin
      tick();
      chk({tag, "_dv_wait"}, {15'd0, data_valid}, 16'd0);
    end
    tick();
    chk({tag, "_dv"}, {15'd0, data_valid}, 16'd1);
    chk({tag, "_data"}, data_out, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data_out"},    data_out,                16'h0000);
    chk({tag, "_data_valid"},  {15'd0, data_valid},     16'd0);
    chk({tag, "_busy"},        {15'd0, busy},           16'd0);
    chk({tag, "_wb_full"},     {15'd0, wb_full},        16'd0);
    chk({tag, "_wb_overflow"}, {15'd0, wb_overflow},    16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    logic [15:0] d;
    int          nw;

    rst_n    = 1'b0;
    addr_in  = 16'h0000;
    data_in  = 16'h0000;
    write_en = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    m_reset();

    // preload RAM through the write path, let it drain
    do_write(16'h0012, 16'hBEEF);
    do_write(16'h0010, 16'h5510);
    do_write(16'h0011, 16'h5511);
    do_write(16'h0034, 16'h0D34);
    do_write(16'h0040, 16'h0E40);
    do_write(16'h0041, 16'h0E41);
    do_write(16'h0042, 16'h0E42);
    idle(3);
    chk("preload_drained_busy", {15'd0, busy}, 16'd0);

    // reset, then first read after reset: BEEF after RD_LAT edges, held while stable
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_reset();
    do_read("rd_beef", 16'h0012);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_beef_hold_dv",   {15'd0, data_valid}, 16'd1);
      chk("rd_beef_hold_data", data_out,            16'hBEEF);
    end

    // repeated identical write held 5 cycles: one push, busy for one cycle
    for (int i = 0; i < 5; i++) begin
      do_write(16'h0005, 16'h1234);
      chk("dup_wr_busy", {15'd0, busy}, (i == 0) ? 16'd1 : 16'd0);
    end
    do_read("rd_after_dup", 16'h0005);
    chk("dup_wr_ovf", {15'd0, wb_overflow}, 16'd0);

    // back-to-back distinct writes keep one entry in flight; immediate read of addr 4
    for (int i = 0; i < 6; i++) begin
      do_write(16'(i), 16'hA000 + 16'(i));
      chk("b2b_busy", {15'd0, busy}, 16'd1);
    end
    do_read("rd_b2b_4", 16'h0004);
    chk("b2b_ovf", {15'd0, wb_overflow}, 16'd0);

    // address change mid-latency restarts the count
    addr_in  = 16'h0010;
    write_en = 1'b0;
    tick();
    tick();
    chk("midlat_dv", {15'd0, data_valid}, 16'd0);
    do_read("rd_restart_11", 16'h0011);

    // stalled drain: fill the buffer, drop a 5th write, forward newest match
    force dut.drain_stall = 1'b1;
    stalled = 1;
    do_write(16'h0030, 16'hC030);
    do_write(16'h0031, 16'hC031);
    do_write(16'h0030, 16'hC130);
    do_write(16'h0032, 16'hC032);
    chk("full_wb_full", {15'd0, wb_full},     {15'd0, q_addr.size() == WB_DEPTH});
    chk("full_ovf_pre", {15'd0, wb_overflow}, {15'd0, m_ovf});
    do_write(16'h0034, 16'hC034);
    chk("full_ovf",     {15'd0, wb_overflow}, {15'd0, m_ovf});
    chk("full_wb_full2",{15'd0, wb_full},     16'd1);
    do_read("rd_fwd_newest_30", 16'h0030);
    do_read("rd_fwd_31",        16'h0031);
    do_read("rd_dropped_34",    16'h0034);
    release dut.drain_stall;
    stalled = 0;
    m_release();
    idle(WB_DEPTH + 1);
    chk("drained_busy",    {15'd0, busy},        16'd0);
    chk("drained_wb_full", {15'd0, wb_full},     16'd0);
    chk("ovf_sticky",      {15'd0, wb_overflow}, 16'd1);
    do_read("rd_ram_30", 16'h0030);
    do_read("rd_ram_34", 16'h0034);
    do_read("rd_ram_32", 16'h0032);
    chk("ovf_sticky2", {15'd0, wb_overflow}, 16'd1);

    // pending writes discarded by a reset pulse
    force dut.drain_stall = 1'b1;
    stalled = 1;
    do_write(16'h0040, 16'hF040);
    do_write(16'h0041, 16'hF041);
    do_write(16'h0042, 16'hF042);
    chk("pend_busy", {15'd0, busy}, 16'd1);
    write_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    chk_reset_outputs("rst_edge");
    rst_n = 1'b1;
    release dut.drain_stall;
    stalled = 0;
    m_reset();
    do_read("rd_post_rst_40", 16'h0040);
    do_read("rd_post_rst_42", 16'h0042);
    do_read("rd_alias_112",   16'h0112);
    chk("rd_alias_112_lit", data_out, 16'hBEEF);

    // randomized mix over a small window, with aliased upper address bits
    for (int i = 0; i < 8; i++) do_write(16'h0020 + 16'(i), 16'(32'h7000 + i));
    for (int it = 0; it < 24; it++) begin
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) begin
        a = {8'($urandom), 8'h20 | 8'($urandom_range(0, 7))};
        d = 16'($urandom);
        do_write(a, d);
      end
      a = {8'($urandom), 8'h20 | 8'($urandom_range(0, 7))};
      if (nw == 0 && hold_valid && a[7:0] == hold_lo) a[2:0] = a[2:0] + 3'd1;
      do_read("rnd_rd", a);
    end
    chk("rnd_ovf", {15'd0, wb_overflow}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
